// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding
// and the canned control vectors driven onto the pipeline enables.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_HALT     = 2'b11
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_hold;
    } ctrl_t;

    localparam ctrl_t OUT_PASS     = 5'b11000;
    localparam ctrl_t OUT_FREEZE   = 5'b00001;
    localparam ctrl_t OUT_BRANCH   = 5'b11110;
    localparam ctrl_t OUT_LOAD_USE = 5'b00010;
    localparam ctrl_t OUT_RESET    = 5'b00110;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && !(&count_q))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: memory wait > branch flush > load-use,
// with a memory-timeout halt and a saturating stall-cycle counter.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int WAIT_W       = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             stat_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    localparam logic [1:0]        FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT   = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    ctrl_t             ctrl, ctrl_out;

    assign wait_inc = wait_cnt_q + WAIT_W'(1);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        timeout_err_d = timeout_err_q;
        ctrl          = OUT_PASS;
        if (state_q == ST_HALT) begin
            ctrl = OUT_FREEZE;
        end else if (mem_busy) begin
            // wait_cnt is 0 in RUN, so the first busy cycle always lands on 1
            ctrl       = OUT_FREEZE;
            wait_cnt_d = wait_inc;
            if (wait_inc == WAIT_LIMIT) begin
                state_d       = ST_HALT;
                timeout_err_d = 1'b1;
            end else if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
            end
        end else begin
            wait_cnt_d = '0;
            if (branch_taken) begin
                ctrl        = OUT_BRANCH;
                flush_cnt_d = FLUSH_RELOAD;
                state_d     = (FLUSH_RELOAD != 2'd0) ? ST_FLUSH : ST_RUN;
            end else if (state_q == ST_FLUSH) begin
                ctrl        = OUT_BRANCH;
                flush_cnt_d = flush_cnt_q - 2'd1;
                state_d     = (flush_cnt_q == 2'd1) ? ST_RUN : ST_FLUSH;
            end else begin
                state_d = ST_RUN;
                if (load_use_hazard) ctrl = OUT_LOAD_USE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ctrl_out     = rst_n ? ctrl : OUT_RESET;
    assign pc_write     = ctrl_out.pc_write;
    assign if_id_write  = ctrl_out.if_id_write;
    assign if_id_flush  = ctrl_out.if_id_flush;
    assign id_ex_bubble = ctrl_out.id_ex_bubble;
    assign ex_mem_hold  = ctrl_out.ex_mem_hold;
    assign timeout_err  = timeout_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl_out.pc_write),
        .clr   (stat_clr),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: dut_a (2-cycle flush, 4-bit counter) and dut_b (3-cycle
// flush, timeout 4) share inputs; each sequence starts from a fresh reset.
module tb_pipeline_stall_controller;

    localparam logic [4:0] P = 5'b11000;
    localparam logic [4:0] F = 5'b00001;
    localparam logic [4:0] B = 5'b11110;
    localparam logic [4:0] L = 5'b00010;
    localparam logic [4:0] R = 5'b00110;

    logic clk = 1'b0;
    logic rst_n, load_use_hazard, branch_taken, mem_busy, stat_clr;
    logic pcw_a, ifw_a, iff_a, bub_a, hld_a, to_a;
    logic pcw_b, ifw_b, iff_b, bub_b, hld_b, to_b;
    logic [3:0]  sc_a;
    logic [15:0] sc_b;
    logic [4:0]  oa, ob;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .WAIT_W(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write(pcw_a), .if_id_write(ifw_a), .if_id_flush(iff_a),
        .id_ex_bubble(bub_a), .ex_mem_hold(hld_a), .stall_count(sc_a), .timeout_err(to_a));

    pipeline_stall_controller #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .WAIT_W(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write(pcw_b), .if_id_write(ifw_b), .if_id_flush(iff_b),
        .id_ex_bubble(bub_b), .ex_mem_hold(hld_b), .stall_count(sc_b), .timeout_err(to_b));

    assign oa = {pcw_a, ifw_a, iff_a, bub_a, hld_a};
    assign ob = {pcw_b, ifw_b, iff_b, bub_b, hld_b};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, step past the edge.
    task automatic cyc(input bit sel, input logic lu, input logic br, input logic mb,
                       input logic clr, input string tag, input logic [4:0] exp);
        load_use_hazard = lu;
        branch_taken    = br;
        mem_busy        = mb;
        stat_clr        = clr;
        @(negedge clk);
        chk(tag, {11'b0, (sel ? ob : oa)}, {11'b0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load_use_hazard = 1'b0; branch_taken = 1'b0;
        mem_busy = 1'b0; stat_clr = 1'b0;
        #2;
        chk("rst_out_a", {11'b0, oa}, {11'b0, R});
        chk("rst_cnt_a", {12'b0, sc_a}, 16'd0);
        chk("rst_to_a", {15'b0, to_a}, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        cyc(0, 0, 0, 0, 0, "pass0", P);
        chk("cnt_pass0", {12'b0, sc_a}, 16'd0);

        cyc(0, 1, 0, 0, 0, "lu", L);
        cyc(0, 0, 0, 0, 0, "lu_next", P);
        chk("cnt_lu", {12'b0, sc_a}, 16'd1);

        cyc(0, 1, 1, 0, 0, "br0", B);
        cyc(0, 1, 0, 0, 0, "br1", B);
        cyc(0, 0, 0, 0, 0, "br_after", P);
        chk("cnt_br", {12'b0, sc_a}, 16'd1);

        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, "mw_freeze", F);
        cyc(0, 1, 0, 0, 0, "mw_lu", L);
        cyc(0, 0, 0, 0, 0, "mw_after", P);
        chk("cnt_mw", {12'b0, sc_a}, 16'd7);

        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, "sat_lu", L);
        chk("cnt_sat", {12'b0, sc_a}, 16'd15);
        cyc(0, 1, 0, 0, 1, "clr_lu", L);
        chk("cnt_clr_inc", {12'b0, sc_a}, 16'd0);
        cyc(0, 1, 0, 0, 0, "lu_again", L);
        chk("cnt_reinc", {12'b0, sc_a}, 16'd1);
        cyc(0, 0, 0, 0, 1, "clr_only", P);
        chk("cnt_clr", {12'b0, sc_a}, 16'd0);
        chk("to_a_quiet", {15'b0, to_a}, 16'd0);

        // dut_b halted during the shared memory-wait above; reset must clear it
        rst_n = 1'b0;
        #1;
        chk("rst_out_b", {11'b0, ob}, {11'b0, R});
        chk("rst_to_b", {15'b0, to_b}, 16'd0);
        chk("rst_cnt_b", sc_b, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cyc(1, 0, 1, 0, 0, "fb_br", B);
        cyc(1, 0, 0, 1, 0, "fb_frz0", F);
        cyc(1, 1, 0, 1, 0, "fb_frz1", F);
        cyc(1, 1, 0, 0, 0, "fb_fl1", B);
        cyc(1, 0, 0, 0, 0, "fb_fl2", B);
        cyc(1, 1, 0, 0, 0, "fb_done", L);
        chk("cnt_fb", sc_b, 16'd3);

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, "w3a", F);
        cyc(1, 0, 0, 0, 0, "w3a_rel", P);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, "w3b", F);
        cyc(1, 0, 0, 0, 0, "w3b_rel", P);
        chk("to_b_quiet", {15'b0, to_b}, 16'd0);

        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, "to_busy", F);
        cyc(1, 0, 0, 0, 0, "halt0", F);
        chk("to_set", {15'b0, to_b}, 16'd1);
        cyc(1, 1, 1, 0, 0, "halt1", F);
        chk("to_sticky", {15'b0, to_b}, 16'd1);
        chk("cnt_halt", sc_b, 16'd15);

        rst_n = 1'b0;
        #1;
        chk("to_rst", {15'b0, to_b}, 16'd0);
        chk("halt_rst_out", {11'b0, ob}, {11'b0, R});
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0, "post_rst", P);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
